ctrl: RTL and testbench
=======================

CTRL -- requirements
Module: ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 Clk  in  1  sole clock; the only state is updated on its rising edge.
REQ-004 Reset  in  1  synchronous active-high reset.
REQ-005 Instruction  in  9  machine word; opcode = [8:5], field F = [4:0], Rn = [3:0].
REQ-006 branch_on  out  1  branch instruction, taken by the datapath when R0 != 0.
REQ-007 write_reg  out  1  register-file write enable.
REQ-008 write_mem  out  1  data-memory write enable.
REQ-009 read_mem  out  1  data-memory read enable.
REQ-010 mem_output  out  1  register write data comes from memory (1) or the ALU (0).
REQ-011 use_imm  out  1  ALU operand B comes from imm (1) or reg2 data (0).
REQ-012 reg1_out  out  4  read address A.
REQ-013 reg2_out  out  4  read address B.
REQ-014 reg_in  out  4  write address.
REQ-015 imm  out  8  decoded immediate.
REQ-016 ALU_OP  out  3  ALU operation code.
REQ-017 halt  out  1  registered sticky halt flag.

Function
REQ-018 ALU_OP codes SHALL be: ADD=000, SUB=001, SLL=010, SLR=011, SLT=100, SEQ=101, PASSB=110, OR=111.
REQ-019 All outputs except halt SHALL be combinational from Instruction, Reset and halt.
REQ-020 Defaults SHALL be: enables 0, reg1_out=0, reg2_out=Rn, reg_in=0, imm={3'b0,F}, ALU_OP=PASSB.
REQ-021 ADD/SUB/SLL/SLR SHALL use opcodes 0000/0001/0010/0011 and compute R0 <= R0 op Rn: write_reg=1, use_imm=0, ALU_OP as named.
REQ-022 LOI (0100) SHALL compute R0 <= {3'b0,F}: write_reg=1, use_imm=1, ALU_OP=PASSB.
REQ-023 LOR (0101) SHALL compute R0 <= R0 | {Instruction[2:0],5'b0}: imm={Instruction[2:0],5'b0}, use_imm=1, ALU_OP=OR, write_reg=1.
REQ-024 MOV (0110) with Instruction[4]=0 SHALL copy R0 <= Rn (reg_in=0, reg2_out=Rn); with Instruction[4]=1 it SHALL copy Rn <= R0 (reg_in=Rn, reg2_out=0); write_reg=1, ALU_OP=PASSB.
REQ-025 Opcode 0111 SHALL decode as NOP with all enables 0.
REQ-026 SLT (1000) and SEQ (1001) SHALL write R0 <= (R0<Rn) or (R0==Rn) as 0/1: write_reg=1.
REQ-027 B (1010) SHALL set branch_on=1 and imm = F sign-extended to 8 bits (PC-relative offset), with write_reg=0.
REQ-028 HALT (1011) SHALL drive all enables 0 and set halt on the next rising edge.
REQ-029 LW (1100) SHALL compute R0 <= mem[Rn]: read_mem=1, mem_output=1, write_reg=1, use_imm=0.
REQ-030 LWI (1101) SHALL compute R0 <= mem[{3'b0,F}]: read_mem=1, mem_output=1, write_reg=1, use_imm=1.
REQ-031 SW (1110) SHALL compute mem[Rn] <= R0: write_mem=1, reg1_out=0 (data), use_imm=0.
REQ-032 SWI (1111) SHALL compute mem[{3'b0,F}] <= R0: write_mem=1, use_imm=1.
REQ-033 Once halt=1, it SHALL stay 1 until reset, with write_reg, write_mem, read_mem and branch_on forced to 0.

Reset
REQ-034 Reset high at a rising edge SHALL clear halt to 0.
REQ-035 Reset SHALL take priority over a simultaneous HALT instruction.
REQ-036 While Reset is high, write_reg, write_mem, read_mem and branch_on SHALL be forced to 0.

Structure
REQ-037 Opcode and ALU_OP constants SHALL live in the shared package ctrl_pkg.
REQ-038 The block SHALL be a single module with no sub-modules: one decode case plus one halt flop.

Verification
REQ-039 Instruction 000000001 (ADD) -> write_reg=1, reg1_out=0000, reg2_out=0001, reg_in=0000, ALU_OP=000, use_imm=0.
REQ-040 Instruction 010100110 (LOR) -> imm=11000000, use_imm=1, ALU_OP=111, write_reg=1.
REQ-041 Instruction 101001010 (B) -> branch_on=1, imm=00001010, write_reg=0; instruction 101011010 -> imm=11111010.
REQ-042 Instruction 111001110 (SW) -> write_mem=1, reg2_out=1110, reg1_out=0000, write_reg=0; instruction 110101101 (LWI) -> read_mem=1, mem_output=1, imm=00001101.
REQ-043 HALT followed by one clock, then ADD -> halt=1 and write_reg=0; after a Reset pulse, ADD -> write_reg=1 and halt=0.
REQ-044 Instruction 011010011 (MOV) -> reg_in=0011, reg2_out=0000; instruction 011000011 -> reg_in=0000, reg2_out=0011.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcode and ALU operation encodings for the ctrl decoder,
// plus small helpers used when forming immediates.
package ctrl_pkg;

    localparam int unsigned INSTR_W  = 9;
    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned FIELD_W  = 5;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned IMM_W    = 8;
    localparam int unsigned ALU_W    = 3;

    // Instruction opcodes, Instruction[8:5]
    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_SLL  = 4'b0010,
        OP_SLR  = 4'b0011,
        OP_LOI  = 4'b0100,
        OP_LOR  = 4'b0101,
        OP_MOV  = 4'b0110,
        OP_NOP  = 4'b0111,
        OP_SLT  = 4'b1000,
        OP_SEQ  = 4'b1001,
        OP_B    = 4'b1010,
        OP_HALT = 4'b1011,
        OP_LW   = 4'b1100,
        OP_LWI  = 4'b1101,
        OP_SW   = 4'b1110,
        OP_SWI  = 4'b1111
    } opcode_t;

    // ALU operation codes driven on ALU_OP
    typedef enum logic [ALU_W-1:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_SLL   = 3'b010,
        ALU_SLR   = 3'b011,
        ALU_SLT   = 3'b100,
        ALU_SEQ   = 3'b101,
        ALU_PASSB = 3'b110,
        ALU_OR    = 3'b111
    } alu_op_t;

    // Zero-extend the 5-bit field to an 8-bit immediate
    function automatic logic [IMM_W-1:0] zext_field(input logic [FIELD_W-1:0] f);
        return {3'b000, f};
    endfunction

    // Sign-extend the 5-bit field to an 8-bit PC-relative offset
    function automatic logic [IMM_W-1:0] sext_field(input logic [FIELD_W-1:0] f);
        return {{3{f[FIELD_W-1]}}, f};
    endfunction

    // LOR immediate: low three instruction bits placed in the top of the byte
    function automatic logic [IMM_W-1:0] lor_imm(input logic [2:0] lo);
        return {lo, 5'b00000};
    endfunction

endpackage

// File: rtl/ctrl.sv
// ctrl: single-cycle instruction decoder with a sticky halt flag.
// Ports:
//   Clk          - sole clock, halt flop updates on rising edge
//   Reset        - synchronous active-high reset, clears halt
//   Instruction  - 9-bit machine word: opcode [8:5], F [4:0], Rn [3:0]
//   branch_on    - branch instruction (datapath takes it when R0 != 0)
//   write_reg    - register-file write enable
//   write_mem    - data-memory write enable
//   read_mem     - data-memory read enable
//   mem_output   - register write data from memory (1) or ALU (0)
//   use_imm      - ALU operand B from imm (1) or reg2 data (0)
//   reg1_out     - read address A
//   reg2_out     - read address B
//   reg_in       - write address
//   imm          - decoded immediate
//   ALU_OP       - ALU operation code
//   halt         - registered sticky halt flag
// All outputs other than halt are combinational from Instruction, Reset, halt.
module ctrl
    import ctrl_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic [INSTR_W-1:0] Instruction,
    output logic               branch_on,
    output logic               write_reg,
    output logic               write_mem,
    output logic               read_mem,
    output logic               mem_output,
    output logic               use_imm,
    output logic [REG_W-1:0]   reg1_out,
    output logic [REG_W-1:0]   reg2_out,
    output logic [REG_W-1:0]   reg_in,
    output logic [IMM_W-1:0]   imm,
    output logic [ALU_W-1:0]   ALU_OP,
    output logic               halt
);

    opcode_t              opcode;
    logic [FIELD_W-1:0]   field;
    logic [REG_W-1:0]     rn;
    logic                 mov_to_rn;
    logic                 block_side_effects;

    assign opcode    = opcode_t'(Instruction[8:5]);
    assign field     = Instruction[4:0];
    assign rn        = Instruction[3:0];
    assign mov_to_rn = Instruction[4];

    // Reset and halt both suppress every state-changing enable
    assign block_side_effects = Reset | halt;

    // Sticky halt flag; reset wins over a simultaneous HALT
    always_ff @(posedge Clk) begin
        if (Reset) begin
            halt <= 1'b0;
        end else if (opcode == OP_HALT) begin
            halt <= 1'b1;
        end
    end

    // Instruction decode
    always_comb begin
        branch_on  = 1'b0;
        write_reg  = 1'b0;
        write_mem  = 1'b0;
        read_mem   = 1'b0;
        mem_output = 1'b0;
        use_imm    = 1'b0;
        reg1_out   = '0;
        reg2_out   = rn;
        reg_in     = '0;
        imm        = zext_field(field);
        ALU_OP     = ALU_PASSB;

        unique case (opcode)
            OP_ADD: begin
                write_reg = 1'b1;
                ALU_OP    = ALU_ADD;
            end
            OP_SUB: begin
                write_reg = 1'b1;
                ALU_OP    = ALU_SUB;
            end
            OP_SLL: begin
                write_reg = 1'b1;
                ALU_OP    = ALU_SLL;
            end
            OP_SLR: begin
                write_reg = 1'b1;
                ALU_OP    = ALU_SLR;
            end
            OP_LOI: begin
                write_reg = 1'b1;
                use_imm   = 1'b1;
            end
            OP_LOR: begin
                write_reg = 1'b1;
                use_imm   = 1'b1;
                imm       = lor_imm(Instruction[2:0]);
                ALU_OP    = ALU_OR;
            end
            OP_MOV: begin
                write_reg = 1'b1;
                // Bit 4 selects direction: R0 <= Rn (0) or Rn <= R0 (1)
                if (mov_to_rn) begin
                    reg_in   = rn;
                    reg2_out = '0;
                end
            end
            OP_NOP: begin
            end
            OP_SLT: begin
                write_reg = 1'b1;
                ALU_OP    = ALU_SLT;
            end
            OP_SEQ: begin
                write_reg = 1'b1;
                ALU_OP    = ALU_SEQ;
            end
            OP_B: begin
                branch_on = 1'b1;
                imm       = sext_field(field);
            end
            OP_HALT: begin
            end
            OP_LW: begin
                write_reg  = 1'b1;
                read_mem   = 1'b1;
                mem_output = 1'b1;
            end
            OP_LWI: begin
                write_reg  = 1'b1;
                read_mem   = 1'b1;
                mem_output = 1'b1;
                use_imm    = 1'b1;
            end
            OP_SW: begin
                write_mem = 1'b1;
            end
            OP_SWI: begin
                write_mem = 1'b1;
                use_imm   = 1'b1;
            end
            default: begin
            end
        endcase

        if (block_side_effects) begin
            branch_on = 1'b0;
            write_reg = 1'b0;
            write_mem = 1'b0;
            read_mem  = 1'b0;
        end
    end

endmodule

// File: tb/tb_ctrl.sv
// tb_ctrl: table vectors, hand-written halt/reset sequences and a randomized
// run compared against an attribute-table reference model of the decoder.
module tb_ctrl;

    typedef struct packed {
        logic       branch_on;
        logic       write_reg;
        logic       write_mem;
        logic       read_mem;
        logic       mem_output;
        logic       use_imm;
        logic [3:0] reg1;
        logic [3:0] reg2;
        logic [3:0] reg_in;
        logic [7:0] imm;
        logic [2:0] alu;
    } out_t;

    typedef struct packed {
        logic [8:0] instr;
        out_t       exp;
    } vec_t;

    logic       Clk;
    logic       Reset;
    logic [8:0] Instruction;
    logic       branch_on, write_reg, write_mem, read_mem, mem_output, use_imm;
    logic [3:0] reg1_out, reg2_out, reg_in;
    logic [7:0] imm;
    logic [2:0] ALU_OP;
    logic       halt;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t vecs[$];

    ctrl dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Instruction(Instruction),
        .branch_on  (branch_on),
        .write_reg  (write_reg),
        .write_mem  (write_mem),
        .read_mem   (read_mem),
        .mem_output (mem_output),
        .use_imm    (use_imm),
        .reg1_out   (reg1_out),
        .reg2_out   (reg2_out),
        .reg_in     (reg_in),
        .imm        (imm),
        .ALU_OP     (ALU_OP),
        .halt       (halt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic out_t pk(input logic b, input logic wr, input logic wm,
                                input logic rm, input logic mo, input logic ui,
                                input logic [3:0] r1, input logic [3:0] r2,
                                input logic [3:0] ri, input logic [7:0] im,
                                input logic [2:0] al);
        out_t o;
        o.branch_on = b;  o.write_reg = wr; o.write_mem = wm;
        o.read_mem = rm;  o.mem_output = mo; o.use_imm = ui;
        o.reg1 = r1; o.reg2 = r2; o.reg_in = ri; o.imm = im; o.alu = al;
        return o;
    endfunction

    function automatic out_t dut_out();
        out_t o;
        o = {branch_on, write_reg, write_mem, read_mem, mem_output, use_imm,
             reg1_out, reg2_out, reg_in, imm, ALU_OP};
        return o;
    endfunction

    // Reference model: per-opcode attribute masks and an ALU lookup
    function automatic out_t model(input logic [8:0] ins, input logic rst, input logic hlt);
        out_t        o;
        int          op;
        logic [15:0] wr_m, ui_m, rd_m, wm_m, br_m;
        logic [4:0]  f;
        op   = int'(ins[8:5]);
        f    = ins[4:0];
        wr_m = 16'h337F;  // ADD..MOV, SLT, SEQ, LW, LWI
        ui_m = 16'hA030;  // LOI, LOR, LWI, SWI
        rd_m = 16'h3000;  // LW, LWI
        wm_m = 16'hC000;  // SW, SWI
        br_m = 16'h0400;  // B
        o.write_reg  = wr_m[op];
        o.use_imm    = ui_m[op];
        o.read_mem   = rd_m[op];
        o.mem_output = rd_m[op];
        o.write_mem  = wm_m[op];
        o.branch_on  = br_m[op];
        o.reg1       = 4'd0;
        if (op == 6 && ins[4]) begin
            o.reg_in = ins[3:0];
            o.reg2   = 4'd0;
        end else begin
            o.reg_in = 4'd0;
            o.reg2   = ins[3:0];
        end
        if (op == 5)       o.imm = 8'(ins[2:0]) * 8'd32;
        else if (op == 10) o.imm = 8'($signed(f));
        else               o.imm = 8'(f);
        if (op <= 3)       o.alu = 3'(op);
        else if (op == 5)  o.alu = 3'd7;
        else if (op == 8)  o.alu = 3'd4;
        else if (op == 9)  o.alu = 3'd5;
        else               o.alu = 3'd6;
        if (rst || hlt) begin
            o.write_reg = 1'b0;
            o.write_mem = 1'b0;
            o.read_mem  = 1'b0;
            o.branch_on = 1'b0;
        end
        return o;
    endfunction

    task automatic check_out(input string name, input out_t got, input out_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%b required=%b", name, got, exp);
        end
    endtask

    task automatic add_vec(input logic [8:0] ins, input out_t e);
        vec_t v;
        v.instr = ins;
        v.exp   = e;
        vecs.push_back(v);
    endtask

    // Clear halt with a reset edge, then present ins with Reset low
    task automatic fresh(input logic [8:0] ins);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset       = 1'b0;
        Instruction = ins;
        #1;
    endtask

    logic [8:0] cur_ins;
    logic       cur_rst;
    logic       m_halt;

    initial begin
        Reset       = 1'b1;
        Instruction = 9'b000000001;

        //                  b  wr wm rm mo ui r1    r2     ri     imm     alu
        add_vec(9'b000000001, pk(0,1,0,0,0,0,4'd0, 4'd1,  4'd0, 8'h01, 3'b000)); // ADD
        add_vec(9'b010100110, pk(0,1,0,0,0,1,4'd0, 4'd6,  4'd0, 8'hC0, 3'b111)); // LOR
        add_vec(9'b101001010, pk(1,0,0,0,0,0,4'd0, 4'd10, 4'd0, 8'h0A, 3'b110)); // B +
        add_vec(9'b101011010, pk(1,0,0,0,0,0,4'd0, 4'd10, 4'd0, 8'hFA, 3'b110)); // B -
        add_vec(9'b111001110, pk(0,0,1,0,0,0,4'd0, 4'd14, 4'd0, 8'h0E, 3'b110)); // SW
        add_vec(9'b110101101, pk(0,1,0,1,1,1,4'd0, 4'd13, 4'd0, 8'h0D, 3'b110)); // LWI
        add_vec(9'b011010011, pk(0,1,0,0,0,0,4'd0, 4'd0,  4'd3, 8'h13, 3'b110)); // MOV Rn<=R0
        add_vec(9'b011000011, pk(0,1,0,0,0,0,4'd0, 4'd3,  4'd0, 8'h03, 3'b110)); // MOV R0<=Rn
        add_vec(9'b101100101, pk(0,0,0,0,0,0,4'd0, 4'd5,  4'd0, 8'h05, 3'b110)); // HALT
        add_vec(9'b011111111, pk(0,0,0,0,0,0,4'd0, 4'd15, 4'd0, 8'h1F, 3'b110)); // NOP
        add_vec(9'b100000111, pk(0,1,0,0,0,0,4'd0, 4'd7,  4'd0, 8'h07, 3'b100)); // SLT
        add_vec(9'b100110000, pk(0,1,0,0,0,0,4'd0, 4'd0,  4'd0, 8'h10, 3'b101)); // SEQ
        add_vec(9'b010011111, pk(0,1,0,0,0,1,4'd0, 4'd15, 4'd0, 8'h1F, 3'b110)); // LOI
        add_vec(9'b000100100, pk(0,1,0,0,0,0,4'd0, 4'd4,  4'd0, 8'h04, 3'b001)); // SUB
        add_vec(9'b110000010, pk(0,1,0,1,1,0,4'd0, 4'd2,  4'd0, 8'h02, 3'b110)); // LW
        add_vec(9'b111110001, pk(0,0,1,0,0,1,4'd0, 4'd1,  4'd0, 8'h11, 3'b110)); // SWI
        add_vec(9'b001000000, pk(0,1,0,0,0,0,4'd0, 4'd0,  4'd0, 8'h00, 3'b010)); // SLL
        add_vec(9'b001101000, pk(0,1,0,0,0,0,4'd0, 4'd8,  4'd0, 8'h08, 3'b011)); // SLR

        // Reset state
        @(posedge Clk);
        #1;
        check_bit("reset_halt", halt, 1'b0);
        check_bit("reset_blocks_write", write_reg, 1'b0);

        // Table vectors
        for (int i = 0; i < vecs.size(); i++) begin
            fresh(vecs[i].instr);
            check_out($sformatf("vec%0d_%b", i, vecs[i].instr), dut_out(), vecs[i].exp);
        end

        // HALT, one clock, then ADD: halted and writes suppressed
        fresh(9'b101100000);
        @(posedge Clk);
        #1;
        Instruction = 9'b000000001;
        #1;
        check_bit("halt_set", halt, 1'b1);
        check_bit("halt_blocks_write", write_reg, 1'b0);
        check_out("halt_add_outputs", dut_out(),
                  pk(0,0,0,0,0,0,4'd0,4'd1,4'd0,8'h01,3'b000));
        // Sticky across further edges
        Instruction = 9'b111001110;
        @(posedge Clk);
        #1;
        check_bit("halt_sticky", halt, 1'b1);
        check_bit("halt_blocks_mem", write_mem, 1'b0);
        Instruction = 9'b101001010;
        #1;
        check_bit("halt_blocks_branch", branch_on, 1'b0);
        // Reset pulse restores normal decode
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset       = 1'b0;
        Instruction = 9'b000000001;
        #1;
        check_bit("unhalt_halt", halt, 1'b0);
        check_bit("unhalt_write", write_reg, 1'b1);

        // Reset wins over a simultaneous HALT; enables gated while in reset
        Reset       = 1'b1;
        Instruction = 9'b101100000;
        @(posedge Clk);
        #1;
        check_bit("reset_beats_halt", halt, 1'b0);
        Instruction = 9'b110000010;
        #1;
        check_bit("reset_gates_read", read_mem, 1'b0);
        check_bit("reset_gates_write", write_reg, 1'b0);
        check_bit("reset_keeps_memout", mem_output, 1'b1);

        // Randomized run against the reference model
        Reset       = 1'b1;
        Instruction = 9'd0;
        @(posedge Clk);
        #1;
        m_halt  = 1'b0;
        cur_ins = Instruction;
        cur_rst = Reset;
        for (int k = 0; k < 600; k++) begin
            cur_ins     = 9'($urandom_range(0, 511));
            cur_rst     = ($urandom_range(0, 9) == 0);
            Instruction = cur_ins;
            Reset       = cur_rst;
            #1;
            check_out($sformatf("rand%0d_%b_r%0d", k, cur_ins, cur_rst), dut_out(),
                      model(cur_ins, cur_rst, m_halt));
            check_bit($sformatf("rand%0d_halt", k), halt, m_halt);
            @(posedge Clk);
            if (cur_rst)                     m_halt = 1'b0;
            else if (cur_ins[8:5] == 4'd11)  m_halt = 1'b1;
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
